mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_if_pkg.sv | 12 +
 rtl/mem_array.sv | 41 ++++
 rtl/mem_responder.sv | 139 +++++++++++++
 tb/tb_mem_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared response codes, FSM encodings and range helper for the memory responder.
package mem_if_pkg;
  localparam int unsigned RESP_OKAY = 0;
  localparam int unsigned RESP_ERR  = 1;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_RESP = 2'd1} rstate_t;
  typedef enum logic [1:0] {W_COLLECT = 2'd0, W_EXEC = 2'd1, W_RESP = 2'd2} wstate_t;

  function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction
endpackage

// File: rtl/mem_array.sv
// Word storage: one synchronous write port, two combinational read ports.
// Reads of unimplemented addresses return zero.
module mem_array #(
  parameter int unsigned ADDR_WDTH = 4,
  parameter int unsigned DATA_WDTH = 32,
  parameter int unsigned MEM_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_WDTH-1:0] waddr,
  input  logic [DATA_WDTH-1:0] wdata,
  input  logic [ADDR_WDTH-1:0] raddr,
  output logic [DATA_WDTH-1:0] rdata,
  input  logic [ADDR_WDTH-1:0] daddr,
  output logic [DATA_WDTH-1:0] ddata
);
  logic [DATA_WDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++)
        if (waddr == ADDR_WDTH'(i)) mem[i] <= wdata;
    end
  end

  // Address decode by match keeps out-of-range lookups at zero without indexing past the array.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < int'(MEM_DEPTH); i++)
      if (raddr == ADDR_WDTH'(i)) rdata = mem[i];
  end

  always_comb begin
    ddata = '0;
    for (int i = 0; i < int'(MEM_DEPTH); i++)
      if (daddr == ADDR_WDTH'(i)) ddata = mem[i];
  end
endmodule

// File: rtl/mem_responder.sv
// Single-outstanding read/write memory responder with valid/ready channels
// (AR/R for reads, AW/W/B for writes) and a combinational debug read port.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_WDTH = 4,
  parameter int unsigned DATA_WDTH = 32,
  parameter int unsigned RESP_WDTH = 1,
  parameter int unsigned MEM_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ar_valid,
  output logic                 ar_ready,
  input  logic [ADDR_WDTH-1:0] ar_addr,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [DATA_WDTH-1:0] r_data,
  input  logic                 aw_valid,
  output logic                 aw_ready,
  input  logic [ADDR_WDTH-1:0] aw_addr,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [DATA_WDTH-1:0] w_data,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [RESP_WDTH-1:0] b_resp,
  input  logic [ADDR_WDTH-1:0] dbg_addr,
  output logic [DATA_WDTH-1:0] dbg_data
);
  rstate_t r_state, r_next;
  wstate_t w_state, w_next;

  logic                 aw_got, w_got;
  logic [ADDR_WDTH-1:0] w_addr;
  logic [DATA_WDTH-1:0] w_buf;
  logic [DATA_WDTH-1:0] rd_word;
  logic                 mem_we;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  assign ar_hs = ar_valid & ar_ready;
  assign r_hs  = r_valid  & r_ready;
  assign aw_hs = aw_valid & aw_ready;
  assign w_hs  = w_valid  & w_ready;
  assign b_hs  = b_valid  & b_ready;

  // ---- read path ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_RESP;
      R_RESP:  if (r_hs)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    ar_ready = (r_state == R_IDLE);
    r_valid  = (r_state == R_RESP);
  end

  // Sampled before any same-edge write commit, so a colliding read sees the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_data <= '0;
    else if (ar_hs) r_data <= rd_word;
  end

  // ---- write path ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_COLLECT;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_COLLECT: if ((aw_got | aw_hs) & (w_got | w_hs)) w_next = W_EXEC;
      W_EXEC:    w_next = W_RESP;
      W_RESP:    if (b_hs) w_next = W_COLLECT;
      default:   w_next = W_COLLECT;
    endcase
  end

  always_comb begin
    aw_ready = (w_state == W_COLLECT) & ~aw_got;
    w_ready  = (w_state == W_COLLECT) & ~w_got;
    b_valid  = (w_state == W_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      w_addr <= '0;
      w_buf  <= '0;
    end else if (b_hs) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_got <= 1'b1;
        w_addr <= aw_addr;
      end
      if (w_hs) begin
        w_got <= 1'b1;
        w_buf <= w_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) b_resp <= '0;
    else if (w_state == W_EXEC)
      b_resp <= in_range(32'(w_addr), MEM_DEPTH) ? RESP_WDTH'(RESP_OKAY) : RESP_WDTH'(RESP_ERR);
  end

  assign mem_we = (w_state == W_EXEC) & in_range(32'(w_addr), MEM_DEPTH);

  mem_array #(
    .ADDR_WDTH(ADDR_WDTH),
    .DATA_WDTH(DATA_WDTH),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (w_addr),
    .wdata (w_buf),
    .raddr (ar_addr),
    .rdata (rd_word),
    .daddr (dbg_addr),
    .ddata (dbg_data)
  );
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (MEM_DEPTH=12): scoreboard queues for R and B,
// popped by an independent monitor on every observed handshake.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [3:0]  ar_addr, aw_addr, dbg_addr;
  logic [31:0] r_data, w_data, dbg_data;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [0:0]  b_resp;

  int checks = 0;
  int fails  = 0;
  logic [31:0] r_exp[$];
  logic [31:0] b_exp[$];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1), .MEM_DEPTH(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    fails++;
    $display("FAIL %s: handshake timed out, expected completion", name);
  endtask

  // Monitor: a handshake seen mid-cycle completes on the next rising edge.
  initial forever begin
    @(negedge clk);
    if (rst_n && r_valid && r_ready) begin
      if (r_exp.size() == 0) begin
        checks++; fails++;
        $display("FAIL r_unexpected: got 0x%0h expected no response", r_data);
      end else chk("r_data", r_data, r_exp.pop_front());
    end
    if (rst_n && b_valid && b_ready) begin
      if (b_exp.size() == 0) begin
        checks++; fails++;
        $display("FAIL b_unexpected: got 0x%0h expected no response", 32'(b_resp));
      end else chk("b_resp", 32'(b_resp), b_exp.pop_front());
    end
  end

  task automatic write_tx(input logic [3:0] a, input logic [31:0] d,
                          input logic [31:0] resp, input bit push);
    int n = 0;
    bit ha, hw;
    if (push) b_exp.push_back(resp);
    aw_addr = a; w_data = d; aw_valid = 1'b1; w_valid = 1'b1;
    while ((aw_valid || w_valid) && n < 20) begin
      @(negedge clk);
      ha = aw_valid && aw_ready;
      hw = w_valid && w_ready;
      @(posedge clk); #1;
      if (ha) aw_valid = 1'b0;
      if (hw) w_valid = 1'b0;
      n++;
    end
    if (aw_valid || w_valid) begin
      timeout("write_tx");
      aw_valid = 1'b0; w_valid = 1'b0;
    end
  endtask

  task automatic send_one(input bit is_aw, input logic [3:0] a, input logic [31:0] d);
    int n = 0;
    bit h = 1'b0;
    if (is_aw) begin aw_addr = a; aw_valid = 1'b1; end
    else       begin w_data = d;  w_valid = 1'b1; end
    while (!h && n < 20) begin
      @(negedge clk);
      h = is_aw ? aw_ready : w_ready;
      @(posedge clk); #1;
      n++;
    end
    aw_valid = 1'b0; w_valid = 1'b0;
    if (!h) timeout("send_one");
  endtask

  task automatic read_tx(input logic [3:0] a, input logic [31:0] exp,
                         input bit push, output int n);
    bit h = 1'b0;
    n = 0;
    if (push) r_exp.push_back(exp);
    ar_addr = a; ar_valid = 1'b1;
    while (!h && n < 20) begin
      @(negedge clk);
      h = ar_ready;
      @(posedge clk); #1;
      n++;
    end
    ar_valid = 1'b0;
    if (!h) timeout("read_tx");
  endtask

  task automatic drain();
    int n = 0;
    while ((r_exp.size() != 0 || b_exp.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(r_exp.size() + b_exp.size()), 32'd0);
  endtask

  task automatic dbg(input logic [3:0] a, input logic [31:0] exp);
    dbg_addr = a; #1;
    chk($sformatf("dbg[%0d]", a), dbg_data, exp);
  endtask

  logic [31:0] model [16];
  int n;

  initial begin
    rst_n = 1'b0;
    ar_valid = 0; ar_addr = 0; r_ready = 1;
    aw_valid = 0; aw_addr = 0; w_valid = 0; w_data = 0; b_ready = 1; dbg_addr = 0;
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ar_ready", 32'(ar_ready), 1);
    chk("rst_aw_ready", 32'(aw_ready), 1);
    chk("rst_w_ready",  32'(w_ready), 1);
    chk("rst_r_valid",  32'(r_valid), 0);
    chk("rst_b_valid",  32'(b_valid), 0);
    chk("rst_r_data",   r_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // AW and W in the same cycle; B appears two cycles after the handshake
    write_tx(4'd3, 32'hDEADBEEF, 0, 1);
    model[3] = 32'hDEADBEEF;
    chk("b_lat_c1", 32'(b_valid), 0);
    chk("aw_ready_busy", 32'(aw_ready), 0);
    @(posedge clk); #1;
    chk("b_lat_c2", 32'(b_valid), 1);
    drain();
    dbg(4'd3, 32'hDEADBEEF);

    // W well ahead of AW: no commit until the address arrives
    b_exp.push_back(0);
    send_one(1'b0, 4'd0, 32'h5);
    for (int k = 0; k < 3; k++) begin
      chk("w_ready_held", 32'(w_ready), 0);
      chk("no_b_early", 32'(b_valid), 0);
      dbg(4'd7, 32'h0);
      @(posedge clk); #1;
    end
    send_one(1'b1, 4'd7, 32'h0);
    model[7] = 32'h5;
    drain();
    dbg(4'd7, 32'h5);

    // Read with back-pressure: payload stable, no new AR until R completes
    r_ready = 1'b0;
    read_tx(4'd7, 32'h5, 1, n);
    for (int k = 0; k < 4; k++) begin
      chk("r_valid_hold", 32'(r_valid), 1);
      chk("r_data_hold", r_data, 32'h5);
      chk("ar_ready_busy", 32'(ar_ready), 0);
      @(posedge clk); #1;
    end
    r_ready = 1'b1;
    read_tx(4'd3, 32'hDEADBEEF, 1, n);
    chk("ar_after_r_cycles", 32'(n), 2);
    drain();

    // Out-of-range write/read
    write_tx(4'd13, 32'h1, 1, 1);
    drain();
    for (int i = 0; i < 12; i++) dbg(4'(i), model[i]);
    dbg(4'd13, 32'h0);
    read_tx(4'd13, 32'h0, 1, n);
    drain();

    // Read on the same edge as a commit to the same word sees the old value
    write_tx(4'd2, 32'hA, 0, 1);
    drain();
    write_tx(4'd2, 32'hB, 0, 1);
    read_tx(4'd2, 32'hA, 1, n);
    chk("collide_ar_cycles", 32'(n), 1);
    drain();
    read_tx(4'd2, 32'hB, 1, n);
    drain();

    // Reset while both responses are pending
    r_ready = 1'b0; b_ready = 1'b0;
    write_tx(4'd5, 32'h77, 0, 0);
    read_tx(4'd3, 32'h0, 0, n);
    chk("pend_b_valid", 32'(b_valid), 1);
    chk("pend_r_valid", 32'(r_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_r_valid", 32'(r_valid), 0);
    chk("arst_b_valid", 32'(b_valid), 0);
    chk("arst_r_data", r_data, 0);
    chk("arst_aw_ready", 32'(aw_ready), 1);
    chk("arst_w_ready", 32'(w_ready), 1);
    for (int i = 0; i < 12; i++) dbg(4'(i), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; r_ready = 1'b1; b_ready = 1'b1;
    @(posedge clk); #1;
    write_tx(4'd4, 32'h1234, 0, 1);
    drain();
    read_tx(4'd4, 32'h1234, 1, n);
    drain();
    dbg(4'd5, 32'h0);
    dbg(4'd4, 32'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
